// File: rtl/retire_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : retire_trace_buffer
// Purpose  : Retirement capture stage between writeback and the trace/log
//            consumer. Classifies each retired record (NOP/branch, REG, LD,
//            ST, STU, HALT), stamps it with an instruction number and cycle
//            count, and queues it in a FIFO drained by a valid/ready consumer.
// Ports    : clk, rst_n           - clock, asynchronous active-low reset
//            ret_*                - retire record from writeback
//            stall_req            - FIFO full, upstream must hold ret_*
//            out_valid/out_ready  - consumer handshake for the head record
//            out_kind..out_mem_data - head record fields
//            halted, done         - HALT accepted / HALT accepted and drained
//            overflow             - sticky, a record was dropped
// Revision : 1.0 - initial release
// ============================================================================
module retire_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ret_valid,
    input  logic [15:0] ret_pc,
    input  logic [15:0] ret_inst,
    input  logic        ret_reg_write,
    input  logic [2:0]  ret_write_reg,
    input  logic [15:0] ret_write_data,
    input  logic        ret_mem_read,
    input  logic        ret_mem_write,
    input  logic [15:0] ret_mem_addr,
    input  logic [15:0] ret_mem_data,
    input  logic        ret_halt,
    output logic        stall_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_kind,
    output logic [31:0] out_inum,
    output logic [31:0] out_cycle,
    output logic [15:0] out_pc,
    output logic [2:0]  out_reg,
    output logic [15:0] out_reg_data,
    output logic [15:0] out_addr,
    output logic [15:0] out_mem_data,
    output logic        halted,
    output logic        done,
    output logic        overflow
);

    localparam logic [2:0] C_KIND_NOP  = 3'd0;
    localparam logic [2:0] C_KIND_REG  = 3'd1;
    localparam logic [2:0] C_KIND_LD   = 3'd2;
    localparam logic [2:0] C_KIND_ST   = 3'd3;
    localparam logic [2:0] C_KIND_STU  = 3'd4;
    localparam logic [2:0] C_KIND_HALT = 3'd5;

    // Record layout: kind | inum | cycle | pc | reg | reg_data | addr | mem_data
    localparam int C_REC_W = 3 + 32 + 32 + 16 + 3 + 16 + 16 + 16;

    localparam logic [PTR_W:0] C_FULL_CNT = DEPTH[PTR_W:0];

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic [31:0]        r_cycle_ctr;
    logic [31:0]        r_inum_ctr;
    logic               r_halted;
    logic               r_overflow;
    logic [C_REC_W-1:0] r_mem [DEPTH];

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic [2:0]         w_kind;
    logic [2:0]         w_reg;
    logic [15:0]        w_reg_data;
    logic [15:0]        w_addr;
    logic [15:0]        w_mem_data;
    logic [C_REC_W-1:0] w_head;
    logic               w_unused;

    // The instruction word is not part of the trace record.
    assign w_unused = ^ret_inst;

    assign w_full = (r_count == C_FULL_CNT);
    assign w_pop  = out_valid && out_ready;
    // A full FIFO still accepts a record when the head leaves the same cycle.
    assign w_push = ret_valid && !r_halted && (!w_full || w_pop);
    assign w_drop = ret_valid && !r_halted && w_full && !w_pop;

    // Classification with priority; fields irrelevant to the kind are zeroed.
    always_comb begin
        w_kind     = C_KIND_NOP;
        w_reg      = 3'd0;
        w_reg_data = 16'd0;
        w_addr     = 16'd0;
        w_mem_data = 16'd0;
        if (ret_halt) begin
            w_kind = C_KIND_HALT;
        end else if (ret_reg_write && ret_mem_write) begin
            w_kind     = C_KIND_STU;
            w_reg      = ret_write_reg;
            w_reg_data = ret_write_data;
            w_addr     = ret_mem_addr;
            w_mem_data = ret_mem_data;
        end else if (ret_reg_write && ret_mem_read) begin
            w_kind     = C_KIND_LD;
            w_reg      = ret_write_reg;
            w_reg_data = ret_write_data;
            w_addr     = ret_mem_addr;
        end else if (ret_reg_write) begin
            w_kind     = C_KIND_REG;
            w_reg      = ret_write_reg;
            w_reg_data = ret_write_data;
        end else if (ret_mem_write) begin
            w_kind     = C_KIND_ST;
            w_addr     = ret_mem_addr;
            w_mem_data = ret_mem_data;
        end
    end

    // Storage is not reset; an empty FIFO presents zeros on every field.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_kind, r_inum_ctr, r_cycle_ctr, ret_pc,
                                w_reg, w_reg_data, w_addr, w_mem_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cycle_ctr <= 32'd0;
            r_inum_ctr  <= 32'd0;
            r_halted    <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (!r_halted) begin
                r_cycle_ctr <= r_cycle_ctr + 32'd1;
            end
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
                r_inum_ctr <= r_inum_ctr + 32'd1;
                if (ret_halt) begin
                    r_halted <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{PTR_W{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{PTR_W{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign out_valid = (r_count != '0);
    assign stall_req = w_full;
    assign halted    = r_halted;
    assign done      = r_halted && (r_count == '0);
    assign overflow  = r_overflow;

    assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;
    assign {out_kind, out_inum, out_cycle, out_pc,
            out_reg, out_reg_data, out_addr, out_mem_data} = w_head;

endmodule
`default_nettype wire

// File: tb/tb_retire_trace_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_retire_trace_buffer
// Purpose  : Self-checking bench for retire_trace_buffer. Directed steps plus
//            a randomized phase, compared against a queue-based reference
//            model of the trace FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_retire_trace_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ret_valid = 1'b0;
    logic [15:0] ret_pc = '0;
    logic [15:0] ret_inst = '0;
    logic        ret_reg_write = 1'b0;
    logic [2:0]  ret_write_reg = '0;
    logic [15:0] ret_write_data = '0;
    logic        ret_mem_read = 1'b0;
    logic        ret_mem_write = 1'b0;
    logic [15:0] ret_mem_addr = '0;
    logic [15:0] ret_mem_data = '0;
    logic        ret_halt = 1'b0;
    logic        stall_req;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_kind;
    logic [31:0] out_inum;
    logic [31:0] out_cycle;
    logic [15:0] out_pc;
    logic [2:0]  out_reg;
    logic [15:0] out_reg_data;
    logic [15:0] out_addr;
    logic [15:0] out_mem_data;
    logic        halted;
    logic        done;
    logic        overflow;

    always #5 clk = ~clk;

    retire_trace_buffer #(.DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ret_valid      (ret_valid),
        .ret_pc         (ret_pc),
        .ret_inst       (ret_inst),
        .ret_reg_write  (ret_reg_write),
        .ret_write_reg  (ret_write_reg),
        .ret_write_data (ret_write_data),
        .ret_mem_read   (ret_mem_read),
        .ret_mem_write  (ret_mem_write),
        .ret_mem_addr   (ret_mem_addr),
        .ret_mem_data   (ret_mem_data),
        .ret_halt       (ret_halt),
        .stall_req      (stall_req),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_kind       (out_kind),
        .out_inum       (out_inum),
        .out_cycle      (out_cycle),
        .out_pc         (out_pc),
        .out_reg        (out_reg),
        .out_reg_data   (out_reg_data),
        .out_addr       (out_addr),
        .out_mem_data   (out_mem_data),
        .halted         (halted),
        .done           (done),
        .overflow       (overflow)
    );

    // Reference model: the trace as a queue of records.
    typedef struct {
        logic [2:0]  kind;
        logic [31:0] inum;
        logic [31:0] cyc;
        logic [15:0] pc;
        logic [2:0]  rg;
        logic [15:0] rd;
        logic [15:0] addr;
        logic [15:0] md;
    } rec_t;

    rec_t        q[$];
    bit          m_halted;
    bit          m_overflow;
    logic [31:0] m_inum;
    logic [31:0] m_cycle;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("stall_req", 32'(stall_req), 32'(q.size() == DEPTH));
        chk("halted",    32'(halted),    32'(m_halted));
        chk("done",      32'(done),      32'(m_halted && q.size() == 0));
        chk("overflow",  32'(overflow),  32'(m_overflow));
        if (q.size() != 0) begin
            chk("out_kind",     32'(out_kind),     32'(q[0].kind));
            chk("out_inum",     out_inum,          q[0].inum);
            chk("out_cycle",    out_cycle,         q[0].cyc);
            chk("out_pc",       32'(out_pc),       32'(q[0].pc));
            chk("out_reg",      32'(out_reg),      32'(q[0].rg));
            chk("out_reg_data", 32'(out_reg_data), 32'(q[0].rd));
            chk("out_addr",     32'(out_addr),     32'(q[0].addr));
            chk("out_mem_data", 32'(out_mem_data), 32'(q[0].md));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"},   32'(out_valid),    32'd0);
        chk({tag, "_stall"},   32'(stall_req),    32'd0);
        chk({tag, "_halted"},  32'(halted),       32'd0);
        chk({tag, "_done"},    32'(done),         32'd0);
        chk({tag, "_ovf"},     32'(overflow),     32'd0);
        chk({tag, "_kind"},    32'(out_kind),     32'd0);
        chk({tag, "_inum"},    out_inum,          32'd0);
        chk({tag, "_cycle"},   out_cycle,         32'd0);
        chk({tag, "_pc"},      32'(out_pc),       32'd0);
        chk({tag, "_reg"},     32'(out_reg),      32'd0);
        chk({tag, "_regdata"}, 32'(out_reg_data), 32'd0);
        chk({tag, "_addr"},    32'(out_addr),     32'd0);
        chk({tag, "_mdata"},   32'(out_mem_data), 32'd0);
    endtask

    // Asserts reset away from a clock edge, checks outputs clear at once,
    // then releases it mid-cycle so the next edge is the first counted cycle.
    task automatic reset_dut(input string tag);
        ret_valid = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        q.delete();
        m_halted = 0;
        m_overflow = 0;
        m_inum = 32'd0;
        m_cycle = 32'd0;
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic drive(input bit v, input logic [15:0] pc, input bit rw,
                         input logic [2:0] wr, input logic [15:0] wd,
                         input bit mr, input bit mw, input logic [15:0] a,
                         input logic [15:0] md, input bit h);
        ret_valid      = v;
        ret_pc         = pc;
        ret_inst       = 16'($urandom);
        ret_reg_write  = rw;
        ret_write_reg  = wr;
        ret_write_data = wd;
        ret_mem_read   = mr;
        ret_mem_write  = mw;
        ret_mem_addr   = a;
        ret_mem_data   = md;
        ret_halt       = h;
    endtask

    task automatic drive_rand(input bit v);
        drive(v, 16'($urandom), 1'($urandom), 3'($urandom), 16'($urandom),
              1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    endtask

    // One clock: predict from model state and current inputs, clock, compare.
    task automatic step();
        bit   full;
        bit   pop;
        bit   push;
        rec_t r;
        full = (q.size() == DEPTH);
        pop  = (q.size() != 0) && out_ready;
        push = ret_valid && !m_halted && (!full || pop);
        if      (ret_halt)                      r.kind = 3'd5;
        else if (ret_reg_write && ret_mem_write) r.kind = 3'd4;
        else if (ret_reg_write && ret_mem_read)  r.kind = 3'd2;
        else if (ret_reg_write)                 r.kind = 3'd1;
        else if (ret_mem_write)                 r.kind = 3'd3;
        else                                    r.kind = 3'd0;
        r.inum = m_inum;
        r.cyc  = m_cycle;
        r.pc   = ret_pc;
        r.rg   = (r.kind inside {3'd1, 3'd2, 3'd4}) ? ret_write_reg  : 3'd0;
        r.rd   = (r.kind inside {3'd1, 3'd2, 3'd4}) ? ret_write_data : 16'd0;
        r.addr = (r.kind inside {3'd2, 3'd3, 3'd4}) ? ret_mem_addr   : 16'd0;
        r.md   = (r.kind inside {3'd3, 3'd4})       ? ret_mem_data   : 16'd0;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(r);
            m_inum = m_inum + 32'd1;
        end
        if (ret_valid && !m_halted && full && !pop) m_overflow = 1;
        if (!m_halted) m_cycle = m_cycle + 32'd1;
        if (push && ret_halt) m_halted = 1;
        #1;
        check_model();
    endtask

    initial begin
        #2;
        reset_dut("rst0");

        // REG r3 = 0x00AB at pc 0x0002 on the first cycle after reset.
        drive(1, 16'h0002, 1, 3'd3, 16'h00AB, 0, 0, 16'h1111, 16'h2222, 0);
        step();
        chk("t1_kind", 32'(out_kind), 32'd1);
        chk("t1_inum", out_inum, 32'd0);
        chk("t1_cycle", out_cycle, 32'd0);
        chk("t1_reg", 32'(out_reg), 32'd3);
        chk("t1_data", 32'(out_reg_data), 32'h00AB);
        ret_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("t1_empty", 32'(out_valid), 32'd0);

        // LD, ST, STU, NOP sequence.
        reset_dut("rst1");
        drive(1, 16'h0010, 1, 3'd1, 16'h0005, 1, 0, 16'h0010, 16'h7777, 0); step();
        drive(1, 16'h0012, 0, 3'd4, 16'h3333, 0, 1, 16'h0020, 16'h0007, 0); step();
        drive(1, 16'h0014, 1, 3'd2, 16'h0022, 0, 1, 16'h0022, 16'h0009, 0); step();
        drive(1, 16'h0016, 0, 3'd5, 16'h4444, 0, 0, 16'h5555, 16'h6666, 0); step();
        ret_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_inum", out_inum, 32'(i));
            step();
        end

        // Fill, overflow, drain in order.
        reset_dut("rst2");
        for (int i = 0; i < DEPTH; i++) begin
            drive_rand(1);
            step();
        end
        chk("t3_stall", 32'(stall_req), 32'd1);
        drive_rand(1);
        step();
        chk("t3_ovf", 32'(overflow), 32'd1);
        ret_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t3_drain_inum", out_inum, 32'(i));
            step();
        end
        out_ready = 1'b0;
        drive_rand(1);
        step();
        chk("t3_next_inum", out_inum, 32'd8);

        // Push and pop together while full.
        reset_dut("rst3");
        for (int i = 0; i < DEPTH; i++) begin
            drive_rand(1);
            step();
        end
        drive_rand(1);
        out_ready = 1'b1;
        step();
        chk("t4_stall", 32'(stall_req), 32'd1);
        chk("t4_ovf", 32'(overflow), 32'd0);
        ret_valid = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) step();
        chk("t4_last_inum", out_inum, 32'd8);
        step();

        // Randomized traffic.
        reset_dut("rst4");
        for (int i = 0; i < 400; i++) begin
            drive_rand(($urandom % 4) != 0);
            out_ready = (($urandom % 3) != 0);
            step();
        end

        // HALT with two records queued ahead of it.
        reset_dut("rst5");
        drive_rand(1); step();
        drive_rand(1); step();
        drive(1, 16'h0040, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
        step();
        chk("t5_halted", 32'(halted), 32'd1);
        chk("t5_done0", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive_rand(1);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand(1);
            step();
        end
        chk("t5_done", 32'(done), 32'd1);

        // Reset while records are queued.
        reset_dut("rst6");
        for (int i = 0; i < 3; i++) begin
            drive_rand(1);
            step();
        end
        reset_dut("rst7");
        drive_rand(1);
        step();
        chk("t6_inum", out_inum, 32'd0);
        chk("t6_cycle", out_cycle, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
